// File: rtl/net2axis_sink.sv
// net2axis_sink: AXI4-Stream sink/checker for the net2axis master stage.
//   Drives a registered TREADY using one of three patterns: always high,
//   periodic, or LFSR-driven. Counts packets and bytes, records the length
//   of the last completed packet, and raises sticky protocol error flags.
//   DONE goes high once EXPECTED_PKTS packets have completed.
// Ports:
//   ACLK, ARESET (async, active high), ENABLE (when low, TREADY is held low)
//   S_AXIS_*      : stream input (TVALID/TDATA/TKEEP/TLAST in, TREADY out)
//   PKT_COUNT, BYTE_COUNT, LAST_PKT_BYTES : saturating statistics
//   ERR_KEEP, ERR_STABLE, ERR_OVERRUN, DONE : sticky status
module net2axis_sink #(
  parameter int          TDATA_WIDTH   = 32,
  parameter int          EXPECTED_PKTS = 1,
  parameter int          READY_MODE    = 0,
  parameter int          READY_PERIOD  = 4,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     ENABLE,
  input  logic                     S_AXIS_TVALID,
  input  logic [TDATA_WIDTH-1:0]   S_AXIS_TDATA,
  input  logic [TDATA_WIDTH/8-1:0] S_AXIS_TKEEP,
  input  logic                     S_AXIS_TLAST,
  output logic                     S_AXIS_TREADY,
  output logic [31:0]              PKT_COUNT,
  output logic [31:0]              BYTE_COUNT,
  output logic [15:0]              LAST_PKT_BYTES,
  output logic                     ERR_KEEP,
  output logic                     ERR_STABLE,
  output logic                     ERR_OVERRUN,
  output logic                     DONE
);
  localparam int KW  = TDATA_WIDTH / 8;
  localparam int PW  = $clog2(KW + 1);
  localparam int PCW = (READY_PERIOD > 1) ? $clog2(READY_PERIOD) : 1;

  typedef enum logic [1:0] {IDLE, IN_PKT, FINISHED} state_t;

  state_t                 state_q, state_d;
  logic                   tready_q, tready_d;
  logic [15:0]            lfsr_q, lfsr_d;
  logic [PCW-1:0]         pcnt_q, pcnt_d;
  logic [31:0]            pkt_q, pkt_d, byte_q, byte_d;
  logic [15:0]            acc_q, acc_d, lastb_q, lastb_d;
  logic                   errk_q, errk_d, errs_q, errs_d, erro_q, erro_d;
  logic                   stall_q, stall_d, slast_q, slast_d;
  logic [TDATA_WIDTH-1:0] sdata_q, sdata_d;
  logic [KW-1:0]          skeep_q, skeep_d;

  logic          beat, counted, reach, keep_bad;
  logic [PW-1:0] pop;
  logic [32:0]   byte_sum;
  logic [16:0]   acc_sum;
  logic [15:0]   acc_sat;

  assign beat    = S_AXIS_TVALID & tready_q;
  assign counted = beat && (state_q != FINISHED);
  // Completing the next packet would bring the total to EXPECTED_PKTS.
  assign reach   = (EXPECTED_PKTS != 0) &&
                   (({1'b0, pkt_q} + 33'd1) == 33'(EXPECTED_PKTS));

  always_comb begin
    pop = '0;
    for (int i = 0; i < KW; i++) pop = pop + PW'(S_AXIS_TKEEP[i]);
  end

  // Last beats need a nonzero LSB-aligned run of ones (x & (x+1) == 0).
  always_comb begin
    if (S_AXIS_TLAST)
      keep_bad = (S_AXIS_TKEEP == '0) ||
                 ((S_AXIS_TKEEP & (S_AXIS_TKEEP + KW'(1))) != '0);
    else
      keep_bad = ~&S_AXIS_TKEEP;
  end

  // ---------------- FSM: state register ----------------
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:     if (beat) state_d = S_AXIS_TLAST ? (reach ? FINISHED : IDLE) : IN_PKT;
      IN_PKT:   if (beat && S_AXIS_TLAST) state_d = reach ? FINISHED : IDLE;
      FINISHED: state_d = FINISHED;
      default:  state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    DONE = (state_q == FINISHED);
  end

  // ---------------- ready pattern generators ----------------
  always_comb begin
    lfsr_d   = lfsr_q;
    pcnt_d   = pcnt_q;
    tready_d = 1'b0;
    if (ENABLE) begin
      // Fibonacci form of x^16 + x^14 + x^13 + x^11 + 1, shifting right.
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
      pcnt_d = (pcnt_q == PCW'(READY_PERIOD - 1)) ? '0 : pcnt_q + PCW'(1);
      case (READY_MODE)
        1:       tready_d = (pcnt_q == '0);
        2:       tready_d = lfsr_q[0] | lfsr_q[1];
        default: tready_d = 1'b1;
      endcase
    end
  end

  // ---------------- counters and checks ----------------
  assign byte_sum = {1'b0, byte_q} + 33'(pop);
  assign acc_sum  = {1'b0, acc_q} + 17'(pop);
  assign acc_sat  = acc_sum[16] ? 16'hFFFF : acc_sum[15:0];

  always_comb begin
    pkt_d   = pkt_q;
    byte_d  = byte_q;
    acc_d   = acc_q;
    lastb_d = lastb_q;
    if (counted) begin
      byte_d = byte_sum[32] ? 32'hFFFF_FFFF : byte_sum[31:0];
      if (S_AXIS_TLAST) begin
        lastb_d = acc_sat;
        acc_d   = '0;
        pkt_d   = (&pkt_q) ? pkt_q : pkt_q + 32'd1;
      end else begin
        acc_d = acc_sat;
      end
    end
  end

  // Snapshot the bus every cycle; it is only compared when stall_q is set.
  always_comb begin
    stall_d = S_AXIS_TVALID & ~tready_q;
    sdata_d = S_AXIS_TDATA;
    skeep_d = S_AXIS_TKEEP;
    slast_d = S_AXIS_TLAST;
    errk_d  = errk_q | (beat & keep_bad);
    erro_d  = erro_q | (beat & (state_q == FINISHED));
    errs_d  = errs_q | (stall_q & (~S_AXIS_TVALID | (S_AXIS_TDATA != sdata_q) |
                                   (S_AXIS_TKEEP != skeep_q) | (S_AXIS_TLAST != slast_q)));
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      tready_q <= 1'b0;
      lfsr_q   <= LFSR_SEED;
      pcnt_q   <= '0;
      pkt_q    <= '0;
      byte_q   <= '0;
      acc_q    <= '0;
      lastb_q  <= '0;
      errk_q   <= 1'b0;
      errs_q   <= 1'b0;
      erro_q   <= 1'b0;
      stall_q  <= 1'b0;
      sdata_q  <= '0;
      skeep_q  <= '0;
      slast_q  <= 1'b0;
    end else begin
      tready_q <= tready_d;
      lfsr_q   <= lfsr_d;
      pcnt_q   <= pcnt_d;
      pkt_q    <= pkt_d;
      byte_q   <= byte_d;
      acc_q    <= acc_d;
      lastb_q  <= lastb_d;
      errk_q   <= errk_d;
      errs_q   <= errs_d;
      erro_q   <= erro_d;
      stall_q  <= stall_d;
      sdata_q  <= sdata_d;
      skeep_q  <= skeep_d;
      slast_q  <= slast_d;
    end
  end

  assign S_AXIS_TREADY  = tready_q;
  assign PKT_COUNT      = pkt_q;
  assign BYTE_COUNT     = byte_q;
  assign LAST_PKT_BYTES = lastb_q;
  assign ERR_KEEP       = errk_q;
  assign ERR_STABLE     = errs_q;
  assign ERR_OVERRUN    = erro_q;
endmodule

// File: tb/tb_net2axis_sink.sv
// Bench for net2axis_sink. Four instances share one input bus:
//   [0] mode 0, 2 packets expected  (table-driven vectors)
//   [1] mode 1, period 4            (backpressure sequence)
//   [2] mode 2, seed ACE1           (LFSR reference model)
//   [3] mode 0, 1 packet expected   (overrun sequence)
module tb_net2axis_sink;
  localparam int N = 4;
  localparam int EXP_P  [N] = '{2, 0, 0, 1};
  localparam int MODE_P [N] = '{0, 1, 2, 0};

  logic        clk = 1'b0;
  logic        rst, en, vld, last;
  logic [31:0] data;
  logic [3:0]  keep;

  logic        tready [N];
  logic [31:0] pkt [N], bytes [N];
  logic [15:0] lastb [N];
  logic        errk [N], errs [N], erro [N], done [N];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    net2axis_sink #(
      .TDATA_WIDTH(32), .EXPECTED_PKTS(EXP_P[g]), .READY_MODE(MODE_P[g]),
      .READY_PERIOD(4), .LFSR_SEED(16'hACE1)
    ) u_dut (
      .ACLK(clk), .ARESET(rst), .ENABLE(en),
      .S_AXIS_TVALID(vld), .S_AXIS_TDATA(data), .S_AXIS_TKEEP(keep),
      .S_AXIS_TLAST(last), .S_AXIS_TREADY(tready[g]),
      .PKT_COUNT(pkt[g]), .BYTE_COUNT(bytes[g]), .LAST_PKT_BYTES(lastb[g]),
      .ERR_KEEP(errk[g]), .ERR_STABLE(errs[g]), .ERR_OVERRUN(erro[g]), .DONE(done[g])
    );
  end

  typedef struct {
    logic        rst, en, vld;
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        tready;
    logic [31:0] pkt, bytes;
    logic [15:0] lastb;
    logic [3:0]  flags; // {ERR_KEEP, ERR_STABLE, ERR_OVERRUN, DONE}
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic e, input logic v, input logic [31:0] d,
                     input logic [3:0] k, input logic l, input logic tr,
                     input logic [31:0] p, input logic [31:0] b, input logic [15:0] lb,
                     input logic [3:0] f);
    vec_t x;
    x.rst = r; x.en = e; x.vld = v; x.data = d; x.keep = k; x.last = l;
    x.tready = tr; x.pkt = p; x.bytes = b; x.lastb = lb; x.flags = f;
    tbl.push_back(x);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", nm, act, exp);
    end
  endtask

  // Reset for one cycle, then release with ENABLE high and the bus idle.
  task automatic rst_seq();
    rst = 1'b1; en = 1'b0; vld = 1'b0; last = 1'b0; keep = 4'hF; data = '0;
    @(negedge clk);
    rst = 1'b0; en = 1'b1;
  endtask

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    logic fb;
    fb = s[0] ^ s[2] ^ s[3] ^ s[5];
    return {fb, s[15:1]};
  endfunction

  initial begin
    logic [15:0] m;
    logic        prev_rdy;
    int          n;

    // ---- vector table for instance 0 ----
    add(1,0,0,0,4'hF,0, 0, 0,0,0, 4'b0000);                     // reset state
    add(0,1,0,0,4'hF,0, 1, 0,0,0, 4'b0000);                     // first ready
    for (int i = 0; i < 15; i++)                                // 60-byte packet
      add(0,1,1,i,4'hF,i==14, 1, (i==14)?1:0, 4*(i+1), (i==14)?60:0, 4'b0000);
    for (int j = 0; j < 16; j++)                                // 61-byte packet
      add(0,1,1,100+j,(j==15)?4'h1:4'hF,j==15, 1, (j==15)?2:1,
          (j==15)?121:60+4*(j+1), (j==15)?61:60, (j==15)?4'b0001:4'b0000);
    add(0,1,0,0,4'hF,0, 1, 2,121,61, 4'b0001);                  // DONE holds
    add(1,0,0,0,4'hF,0, 0, 0,0,0, 4'b0000);
    add(0,1,0,0,4'hF,0, 1, 0,0,0, 4'b0000);
    for (int i = 0; i < 5; i++)                                 // partial packet
      add(0,1,1,i,4'hF,0, 1, 0,4*(i+1),0, 4'b0000);
    add(1,0,0,0,4'hF,0, 0, 0,0,0, 4'b0000);                     // mid-packet reset
    add(0,1,0,0,4'hF,0, 1, 0,0,0, 4'b0000);
    for (int i = 0; i < 10; i++)                                // full 40-byte packet
      add(0,1,1,i,4'hF,i==9, 1, (i==9)?1:0, 4*(i+1), (i==9)?40:0, 4'b0000);
    add(1,0,0,0,4'hF,0, 0, 0,0,0, 4'b0000);
    add(0,1,0,0,4'hF,0, 1, 0,0,0, 4'b0000);
    add(0,1,1,0,4'h7,0, 1, 0,3,0, 4'b1000);                     // partial keep mid-packet
    add(0,1,1,0,4'hF,1, 1, 1,7,7, 4'b1000);
    add(1,0,0,0,4'hF,0, 0, 0,0,0, 4'b0000);
    add(0,1,0,0,4'hF,0, 1, 0,0,0, 4'b0000);
    add(0,1,1,0,4'h5,1, 1, 1,2,2, 4'b1000);                     // non-contiguous last keep
    add(0,0,0,0,4'hF,0, 0, 1,2,2, 4'b1000);                     // ENABLE drop
    add(0,0,1,32'hAA,4'hF,0, 0, 1,2,2, 4'b1000);                // stall
    add(0,0,1,32'hBB,4'hF,0, 0, 1,2,2, 4'b1100);                // data changed in stall
    add(0,1,0,0,4'hF,0, 1, 1,2,2, 4'b1100);
    add(0,1,0,0,4'hF,0, 1, 1,2,2, 4'b1100);                     // sticky
    add(1,0,0,0,4'hF,0, 0, 0,0,0, 4'b0000);                     // cleared by reset

    foreach (tbl[i]) begin
      rst = tbl[i].rst; en = tbl[i].en; vld = tbl[i].vld;
      data = tbl[i].data; keep = tbl[i].keep; last = tbl[i].last;
      @(negedge clk);
      chk($sformatf("v%0d.tready", i), 32'(tready[0]), 32'(tbl[i].tready));
      chk($sformatf("v%0d.pkt", i), pkt[0], tbl[i].pkt);
      chk($sformatf("v%0d.bytes", i), bytes[0], tbl[i].bytes);
      chk($sformatf("v%0d.lastb", i), 32'(lastb[0]), 32'(tbl[i].lastb));
      chk($sformatf("v%0d.flags", i), 32'({errk[0], errs[0], erro[0], done[0]}),
          32'(tbl[i].flags));
    end

    // ---- overrun: EXPECTED_PKTS = 1, two single-beat packets ----
    rst_seq();
    @(negedge clk);
    vld = 1'b1; last = 1'b1; keep = 4'hF; data = 32'h11;
    @(negedge clk);
    chk("ovr.done1", 32'(done[3]), 32'd1);
    chk("ovr.flag1", 32'(erro[3]), 32'd0);
    data = 32'h22;
    @(negedge clk);
    vld = 1'b0;
    chk("ovr.flag2", 32'(erro[3]), 32'd1);
    chk("ovr.pkt", pkt[3], 32'd1);
    chk("ovr.bytes", bytes[3], 32'd4);

    // ---- periodic ready: continuously valid source, 8-beat packets ----
    rst_seq();
    n = 0; vld = 1'b1; data = 32'd0; keep = 4'hF; last = 1'b0; prev_rdy = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      @(negedge clk);
      chk($sformatf("per.tready%0d", k), 32'(tready[1]), 32'(((k - 1) % 4) == 0));
      if (prev_rdy) begin
        n++; data = 32'(n); last = ((n % 8) == 7);
      end
      prev_rdy = tready[1];
    end
    vld = 1'b0;
    chk("per.pkt", pkt[1], 32'd1);
    chk("per.bytes", bytes[1], 32'd32);
    chk("per.stable", 32'(errs[1]), 32'd0);
    chk("per.done", 32'(done[1]), 32'd0);

    // ---- LFSR ready against reference model ----
    rst_seq();
    m = 16'hACE1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      chk($sformatf("lfsr%0d", k), 32'(tready[2]), 32'(m[0] | m[1]));
      m = lfsr_step(m);
    end
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("lfsr.off%0d", k), 32'(tready[2]), 32'd0);
    end
    en = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("lfsr.resume%0d", k), 32'(tready[2]), 32'(m[0] | m[1]));
      m = lfsr_step(m);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
